// File: rtl/seq_sorter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_sorter_pkg : shared state encoding and sizing helper for seq_sorter  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package seq_sorter_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SORT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Bits needed to hold values 0..value-1.
   function automatic int clog2(input int value);
      int r_bits;
      int v;
      r_bits = 0;
      v      = value - 1;
      while (v > 0) begin
         r_bits = r_bits + 1;
         v      = v >> 1;
      end
      return r_bits;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seq_sorter_compare_exchange.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | compare_exchange : orders one adjacent element pair (ascending/descending)|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module compare_exchange #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] lo,
   input  logic [WIDTH-1:0] hi,
   input  logic             dir,
   output logic [WIDTH-1:0] lo_o,
   output logic [WIDTH-1:0] hi_o
);

   logic w_swap;

   // Strict comparisons so equal values never move.
   assign w_swap = dir ? (hi > lo) : (hi < lo);
   assign lo_o   = w_swap ? hi : lo;
   assign hi_o   = w_swap ? lo : hi;

endmodule
`default_nettype wire

// File: rtl/seq_sorter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_sorter : iterative odd-even transposition sorter, valid/ready I/O    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module seq_sorter
   import seq_sorter_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int N     = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic               descend,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [N*WIDTH-1:0] out_data
);

   localparam int              c_pw   = clog2(N + 1);
   localparam logic [c_pw-1:0] c_last = c_pw'(N - 1);

   state_t                      r_state;
   logic [N-1:0][WIDTH-1:0]     r_elem;
   logic                        r_dir;
   logic [c_pw-1:0]             r_phase;
   logic                        r_in_ready;
   logic                        r_out_valid;

   logic [N-2:0][WIDTH-1:0]     w_lo;
   logic [N-2:0][WIDTH-1:0]     w_hi;
   logic [N-1:0][WIDTH-1:0]     w_next;

   for (genvar i = 0; i < N - 1; i++) begin : g_cx
      compare_exchange #(.WIDTH(WIDTH)) u_cx (
         .lo   (r_elem[i]),
         .hi   (r_elem[i+1]),
         .dir  (r_dir),
         .lo_o (w_lo[i]),
         .hi_o (w_hi[i])
      );
   end

   // Each element takes its pair result for the current parity, or holds if unpaired.
   for (genvar i = 0; i < N; i++) begin : g_sel
      logic [WIDTH-1:0] w_even;
      logic [WIDTH-1:0] w_odd;
      if (i % 2 == 0) begin : g_even_idx
         if (i + 1 < N) begin : g_pair
            assign w_even = w_lo[i];
         end else begin : g_alone
            assign w_even = r_elem[i];
         end
         if (i >= 2) begin : g_pair_odd
            assign w_odd = w_hi[i-1];
         end else begin : g_alone_odd
            assign w_odd = r_elem[i];
         end
      end else begin : g_odd_idx
         assign w_even = w_hi[i-1];
         if (i + 1 < N) begin : g_pair_odd
            assign w_odd = w_lo[i];
         end else begin : g_alone_odd
            assign w_odd = r_elem[i];
         end
      end
      assign w_next[i] = r_phase[0] ? w_odd : w_even;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_elem      <= '0;
         r_dir       <= 1'b0;
         r_phase     <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_elem     <= in_data;
                  r_dir      <= descend;
                  r_phase    <= '0;
                  r_state    <= S_SORT;
                  r_in_ready <= 1'b0;
               end
            end
            S_SORT: begin
               r_elem  <= w_next;
               r_phase <= r_phase + c_pw'(1);
               if (r_phase == c_last) begin
                  r_state     <= S_DONE;
                  r_out_valid <= 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_state     <= S_IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_elem;

endmodule
`default_nettype wire

// File: doc/seq_sorter.md
# seq_sorter

Iterative, parametrised odd-even transposition sorter for N unsigned elements of WIDTH bits. A vector is accepted over a valid/ready handshake and sorted in place, one transposition phase per clock. The result is returned over a second valid/ready handshake in ascending or descending order, selected per vector. It is the sequential, any-size successor to the fixed four-element combinational sorting network and sits between a producer and a consumer that both use valid/ready streams.

## Interface
- WIDTH, default 4: bits per element, ≥1.
- N, default 4: number of elements, ≥2.
- clk  input  1: clock; all state changes on the rising edge.
- rst_n  input  1: one clock; reset is synchronous and active-low.
- in_valid  input  1: in_data and descend are valid.
- in_ready  output  1: block can accept a vector. High only in IDLE.
- in_data  input  N*WIDTH: element i occupies bits [i*WIDTH +: WIDTH].
- descend  input  1: 0 sorts ascending (element 0 smallest); 1 sorts descending. Sampled with in_data.
- out_valid  output  1: out_data holds a finished result.
- out_ready  input  1: consumer takes the result.
- out_data  output  N*WIDTH: sorted vector, same packing as in_data. Driven directly from the element registers.

## Operation
- States:
  - IDLE: in_ready=1.
  - SORT: runs phases 0..N-1.
  - DONE: out_valid=1.
- IDLE→SORT on an edge with in_valid & in_ready. On that edge:
  - load the element registers from in_data;
  - latch descend into dir;
  - clear the phase counter.
- SORT, one phase per edge, phase p = counter value.
  - p even: compare-exchange pairs (0,1), (2,3), …
  - p odd: compare-exchange pairs (1,2), (3,4), …
  - An element with no partner in a phase keeps its value. Examples: N=2 on an odd phase; the last element when N is odd on an even phase.
- Compare-exchange(lo, hi):
  - dir=0: swap if hi < lo, unsigned.
  - dir=1: swap if hi > lo, unsigned.
  - Equal values never swap.
- Transition SORT→DONE on the edge that executes phase N-1. The counter is ceil(log2(N+1)) bits.
- DONE→IDLE on an edge with out_valid & out_ready. Element registers keep their value; out_data stays at the last result until the next load.
- Inputs ignored outside their state:
  - in_valid outside IDLE: no effect.
  - descend and in_data outside the accepting edge: no effect.
  - out_ready outside DONE: no effect.
- N phases always run. There is no early termination, so latency is data-independent.

## Timing
- Reset (rst_n low at an edge):
  - state=IDLE, element registers=0, dir=0, phase counter=0.
  - out_valid=0, out_data=0, in_ready=1 after that edge.
- Reset overrides every other event on the same edge, including a handshake.
- Reset mid-SORT or in DONE aborts and discards the vector. No out_valid pulse follows.
- Latency: out_valid rises exactly N edges after the accepting edge (E0).
- Earliest timeline:
  - E0: accept.
  - E1..EN: phases 0..N-1.
  - EN+1: output handshake.
  - EN+2: next accept.
- Throughput: one vector per N+2 cycles.
- Backpressure: while out_valid=1 and out_ready=0, out_valid and out_data hold stable indefinitely, and in_ready stays 0.
- in_ready and out_valid are pure functions of state (no combinational path from inputs).

## Structure
- Package seq_sorter_pkg holds:
  - the state enum S_IDLE/S_SORT/S_DONE (2-bit encoding);
  - a clog2 constant function used for the phase-counter width.
- Sub-module compare_exchange, parameter WIDTH:
  - inputs lo, hi, dir;
  - outputs lo_o, hi_o;
  - purely combinational.
- Top level instantiates compare_exchange for every adjacent pair 0..N-2. Each cycle it selects, per element, the even-pair or odd-pair result by phase parity. All element registers update in parallel.

## Test plan
Elements listed e0..e(N-1).
- Ascending sort, N=4, WIDTH=4: in=[9,3,7,1], descend=0, out_ready=1 → out_valid exactly 4 edges after accept, out=[1,3,7,9], then in_ready=1 one cycle later.
- Descending sort with a mid-sort input change, N=4: in=[1,3,7,9], descend=1; toggle descend and in_data during SORT → out=[9,7,3,1], unaffected by the mid-sort changes.
- Duplicates and extremes, N=4: in=[5,5,0,15], descend=0 → out=[0,5,5,15]. in=[15,15,15,15] → unchanged.
- Backpressure, N=4: hold out_ready=0 for 3 cycles after out_valid; hold in_valid=1 with a new vector throughout → out_valid and out_data stable, in_ready=0, new vector not accepted until after the output handshake.
- Reset mid-operation, N=4: assert rst_n=0 for one edge during phase 2 → out_valid=0, out_data=0, in_ready=1, no stray result afterwards.
- Odd size, N=5, WIDTH=8: in=[200,150,100,50,0], descend=0 → out=[0,50,100,150,200], out_valid 5 edges after accept.
